// File: rtl/n101_gnrl_icb2wishb_split_pkg.sv
// Shared types and helpers for the ICB-to-Wishbone split bridge.
//   state_t      : bridge FSM states (IDLE, BEAT, RSP)
//   GIW          : width of a lane-group index (at most 4 groups)
//   wb_dw_legal  : true for the supported Wishbone data widths
//   calc_be      : byte enables of an ICB command
package n101_gnrl_icb2wishb_split_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BEAT = 2'd1,
    ST_RSP  = 2'd2
  } state_t;

  localparam int unsigned GIW = 2;

  function automatic bit wb_dw_legal(input int unsigned dw);
    return (dw == 8) || (dw == 16) || (dw == 32);
  endfunction

  // Writes use the mask as-is; reads derive lanes from size and address.
  // Size 3 is treated as a word read.
  function automatic logic [3:0] calc_be(input logic       rd,
                                         input logic [1:0] size,
                                         input logic [1:0] lo,
                                         input logic [3:0] wmask);
    logic [3:0] be;
    if (!rd) begin
      be = wmask;
    end else begin
      case (size)
        2'd0:    be = 4'b0001 << lo;
        2'd1:    be = lo[1] ? 4'b1100 : 4'b0011;
        default: be = 4'b1111;
      endcase
    end
    return be;
  endfunction

endpackage

// File: rtl/n101_gnrl_icb2wishb_grpsel.sv
// Lane-group selector: finds the next group with a nonzero byte-enable
// slice and returns that group's byte enables.
//   be         in  4        byte enables of the whole access
//   cur_g      in  GIW      group currently on the bus
//   from_start in  1        1: search from group 0 inclusive; 0: search after cur_g
//   has_next   out 1        an active group was found
//   next_g     out GIW      index of that group
//   sel        out WB_DW/8  byte enables of next_g
module n101_gnrl_icb2wishb_grpsel
  import n101_gnrl_icb2wishb_split_pkg::*;
#(
  parameter int unsigned WB_DW = 8
) (
  input  logic [3:0]         be,
  input  logic [GIW-1:0]     cur_g,
  input  logic               from_start,
  output logic               has_next,
  output logic [GIW-1:0]     next_g,
  output logic [WB_DW/8-1:0] sel
);

  localparam int unsigned GW = WB_DW / 8;
  localparam int unsigned NB = 32 / WB_DW;

  always_comb begin
    has_next = 1'b0;
    next_g   = '0;
    for (int unsigned g = 0; g < NB; g++) begin
      if (!has_next && (from_start || (g > 32'(cur_g))) && (|be[g*GW +: GW])) begin
        has_next = 1'b1;
        next_g   = GIW'(g);
      end
    end
  end

  assign sel = be[32'(next_g)*GW +: GW];

endmodule

// File: rtl/n101_gnrl_icb2wishb_split.sv
// ICB (32-bit) to narrow Wishbone bridge. Each ICB access is split into one
// Wishbone beat per active lane group; read data is assembled lane-aligned.
//   clk, rst_n          clock, asynchronous active-low reset
//   i_icb_cmd_*         ICB command channel (accepted in IDLE only)
//   i_icb_rsp_*         ICB response channel, held until rsp_ready
//   wb_adr/dat_w/sel/we Wishbone request of the current beat (registered)
//   wb_stb, wb_cyc      strobe / cycle, identical
//   wb_dat_r/ack/err    Wishbone beat completion
module n101_gnrl_icb2wishb_split
  import n101_gnrl_icb2wishb_split_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned WB_DW   = 8,
  parameter int unsigned TMO_CYC = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_icb_cmd_valid,
  output logic               i_icb_cmd_ready,
  input  logic               i_icb_cmd_read,
  input  logic [AW-1:0]      i_icb_cmd_addr,
  input  logic [31:0]        i_icb_cmd_wdata,
  input  logic [3:0]         i_icb_cmd_wmask,
  input  logic [1:0]         i_icb_cmd_size,
  output logic               i_icb_rsp_valid,
  input  logic               i_icb_rsp_ready,
  output logic               i_icb_rsp_err,
  output logic [31:0]        i_icb_rsp_rdata,
  output logic [AW-1:0]      wb_adr,
  output logic [WB_DW-1:0]   wb_dat_w,
  output logic [WB_DW/8-1:0] wb_sel,
  input  logic [WB_DW-1:0]   wb_dat_r,
  output logic               wb_we,
  output logic               wb_stb,
  output logic               wb_cyc,
  input  logic               wb_ack,
  input  logic               wb_err
);

  localparam int unsigned GW       = WB_DW / 8;
  localparam int unsigned TW       = (TMO_CYC < 2) ? 1 : $clog2(TMO_CYC + 1);
  localparam int unsigned TMO_LAST = (TMO_CYC == 0) ? 0 : TMO_CYC - 1;

  if (!wb_dw_legal(WB_DW)) begin : g_bad_dw
    $error("n101_gnrl_icb2wishb_split: WB_DW must be 8, 16 or 32");
  end

  state_t             state;
  logic [AW-3:0]      addr_q;
  logic [31:0]        wdata_q;
  logic [3:0]         be_q;
  logic               read_q;
  logic [GIW-1:0]     cur_g;
  logic [TW-1:0]      tmo_cnt;
  logic               cmd_ready_q;
  logic               stb_q;
  logic               we_q;
  logic               rsp_valid_q;
  logic               err_q;
  logic [31:0]        rdata_q;
  logic [AW-1:0]      adr_q;
  logic [WB_DW-1:0]   dat_w_q;
  logic [GW-1:0]      sel_q;

  // In IDLE the selector looks at the incoming command so the first beat
  // can be registered on the accept edge; afterwards it walks the latched BE.
  logic               idle;
  logic [3:0]         be_cmd;
  logic [3:0]         gs_be;
  logic [31:0]        wdata_src;
  logic [AW-3:0]      addr_src;
  logic               has_next;
  logic [GIW-1:0]     next_g;
  logic [GW-1:0]      next_sel;
  logic [AW-1:0]      next_adr;
  logic [WB_DW-1:0]   next_dat;
  logic               timeout;

  assign idle      = (state == ST_IDLE);
  assign be_cmd    = calc_be(i_icb_cmd_read, i_icb_cmd_size, i_icb_cmd_addr[1:0], i_icb_cmd_wmask);
  assign gs_be     = idle ? be_cmd : be_q;
  assign wdata_src = idle ? i_icb_cmd_wdata : wdata_q;
  assign addr_src  = idle ? i_icb_cmd_addr[AW-1:2] : addr_q;
  assign next_adr  = {addr_src, 2'(32'(next_g) * GW)};
  assign next_dat  = wdata_src[32'(next_g)*WB_DW +: WB_DW];
  assign timeout   = (TMO_CYC != 0) && (32'(tmo_cnt) >= TMO_LAST);

  n101_gnrl_icb2wishb_grpsel #(
    .WB_DW(WB_DW)
  ) u_grpsel (
    .be        (gs_be),
    .cur_g     (cur_g),
    .from_start(idle),
    .has_next  (has_next),
    .next_g    (next_g),
    .sel       (next_sel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      read_q      <= 1'b0;
      cur_g       <= '0;
      tmo_cnt     <= '0;
      cmd_ready_q <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      adr_q       <= '0;
      dat_w_q     <= '0;
      sel_q       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_ready_q && i_icb_cmd_valid) begin
            cmd_ready_q <= 1'b0;
            addr_q      <= i_icb_cmd_addr[AW-1:2];
            wdata_q     <= i_icb_cmd_wdata;
            be_q        <= be_cmd;
            read_q      <= i_icb_cmd_read;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            if (has_next) begin
              state   <= ST_BEAT;
              cur_g   <= next_g;
              tmo_cnt <= '0;
              stb_q   <= 1'b1;
              we_q    <= !i_icb_cmd_read;
              adr_q   <= next_adr;
              dat_w_q <= next_dat;
              sel_q   <= next_sel;
            end else begin
              state       <= ST_RSP;
              rsp_valid_q <= 1'b1;
            end
          end
        end
        ST_BEAT: begin
          // err takes priority over a simultaneous ack; that beat's data is dropped.
          if (wb_err || (!wb_ack && timeout)) begin
            state       <= ST_RSP;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b1;
            rsp_valid_q <= 1'b1;
          end else if (wb_ack) begin
            if (read_q) begin
              rdata_q[32'(cur_g)*WB_DW +: WB_DW] <= wb_dat_r;
            end
            if (has_next) begin
              cur_g   <= next_g;
              tmo_cnt <= '0;
              adr_q   <= next_adr;
              dat_w_q <= next_dat;
              sel_q   <= next_sel;
            end else begin
              state       <= ST_RSP;
              stb_q       <= 1'b0;
              we_q        <= 1'b0;
              rsp_valid_q <= 1'b1;
            end
          end else if (32'(tmo_cnt) < TMO_CYC) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_RSP: begin
          if (i_icb_rsp_ready) begin
            state       <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign i_icb_cmd_ready = cmd_ready_q;
  assign i_icb_rsp_valid = rsp_valid_q;
  assign i_icb_rsp_err   = err_q;
  assign i_icb_rsp_rdata = rdata_q;
  assign wb_adr          = adr_q;
  assign wb_dat_w        = dat_w_q;
  assign wb_sel          = sel_q;
  assign wb_we           = we_q;
  assign wb_stb          = stb_q;
  assign wb_cyc          = stb_q;

endmodule

// File: tb/tb_n101_gnrl_icb2wishb_split.sv
module tb_n101_gnrl_icb2wishb_split;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // ---------------- DUT A: WB_DW=8, TMO_CYC=4 ----------------
  logic        a_cvalid = 1'b0, a_cready, a_cread = 1'b0;
  logic [31:0] a_caddr = '0, a_cwdata = '0;
  logic [3:0]  a_cwmask = '0;
  logic [1:0]  a_csize = '0;
  logic        a_rvalid, a_rready = 1'b0, a_rerr;
  logic [31:0] a_rdata, a_adr;
  logic [7:0]  a_dat_w, a_dat_r;
  logic [0:0]  a_sel;
  logic        a_we, a_stb, a_cyc, a_ack, a_werr;

  n101_gnrl_icb2wishb_split #(.AW(32), .WB_DW(8), .TMO_CYC(4)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .i_icb_cmd_valid(a_cvalid), .i_icb_cmd_ready(a_cready), .i_icb_cmd_read(a_cread),
    .i_icb_cmd_addr(a_caddr), .i_icb_cmd_wdata(a_cwdata), .i_icb_cmd_wmask(a_cwmask),
    .i_icb_cmd_size(a_csize), .i_icb_rsp_valid(a_rvalid), .i_icb_rsp_ready(a_rready),
    .i_icb_rsp_err(a_rerr), .i_icb_rsp_rdata(a_rdata),
    .wb_adr(a_adr), .wb_dat_w(a_dat_w), .wb_sel(a_sel), .wb_dat_r(a_dat_r),
    .wb_we(a_we), .wb_stb(a_stb), .wb_cyc(a_cyc), .wb_ack(a_ack), .wb_err(a_werr)
  );

  // Slave model A: immediate ack, optional error on a chosen beat.
  logic        a_ack_en = 1'b1;
  logic        a_both = 1'b0;
  int unsigned a_err_beat = 99;
  logic [31:0] a_rdat = '0;
  int unsigned beat_cnt = 0;
  int unsigned base = 0;
  logic [31:0] rel;
  logic [31:0] log_adr [256];
  logic [7:0]  log_dat [256];
  logic        log_sel [256];
  logic        log_we  [256];

  assign rel     = beat_cnt - base;
  assign a_ack   = a_stb && a_ack_en && ((rel != a_err_beat) || a_both);
  assign a_werr  = a_stb && (rel == a_err_beat);
  assign a_dat_r = a_rdat[{rel[1:0], 3'b000} +: 8];

  always @(posedge clk) begin
    if (a_stb && (a_ack || a_werr)) begin
      log_adr[beat_cnt[7:0]] <= a_adr;
      log_dat[beat_cnt[7:0]] <= a_dat_w;
      log_sel[beat_cnt[7:0]] <= a_sel[0];
      log_we[beat_cnt[7:0]]  <= a_we;
      beat_cnt <= beat_cnt + 1;
    end
  end

  // ---------------- DUT B: WB_DW=16, default timeout ----------------
  logic        b_cvalid = 1'b0, b_cready, b_cread = 1'b0;
  logic [31:0] b_caddr = '0, b_cwdata = '0;
  logic [3:0]  b_cwmask = '0;
  logic [1:0]  b_csize = '0;
  logic        b_rvalid, b_rready = 1'b0, b_rerr;
  logic [31:0] b_rdata, b_adr;
  logic [15:0] b_dat_w, b_dat_r;
  logic [1:0]  b_sel;
  logic        b_we, b_stb, b_cyc, b_ack, b_werr;

  assign b_ack   = b_stb;
  assign b_werr  = 1'b0;
  assign b_dat_r = 16'hBEEF;

  n101_gnrl_icb2wishb_split #(.AW(32), .WB_DW(16), .TMO_CYC(255)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .i_icb_cmd_valid(b_cvalid), .i_icb_cmd_ready(b_cready), .i_icb_cmd_read(b_cread),
    .i_icb_cmd_addr(b_caddr), .i_icb_cmd_wdata(b_cwdata), .i_icb_cmd_wmask(b_cwmask),
    .i_icb_cmd_size(b_csize), .i_icb_rsp_valid(b_rvalid), .i_icb_rsp_ready(b_rready),
    .i_icb_rsp_err(b_rerr), .i_icb_rsp_rdata(b_rdata),
    .wb_adr(b_adr), .wb_dat_w(b_dat_w), .wb_sel(b_sel), .wb_dat_r(b_dat_r),
    .wb_we(b_we), .wb_stb(b_stb), .wb_cyc(b_cyc), .wb_ack(b_ack), .wb_err(b_werr)
  );

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic issue_a(input logic rd, input logic [31:0] ad, input logic [31:0] wd,
                         input logic [3:0] m, input logic [1:0] sz);
    int unsigned n = 0;
    @(negedge clk);
    a_cvalid = 1'b1; a_cread = rd; a_caddr = ad; a_cwdata = wd; a_cwmask = m; a_csize = sz;
    while (!a_cready && n < 20) begin @(negedge clk); n++; end
    chk("a_cmd_accept", {31'd0, a_cready}, 32'd1);
    @(posedge clk);
    #1 a_cvalid = 1'b0;
  endtask

  task automatic wait_rsp_a(output int unsigned lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!a_rvalid && lat < 50);
  endtask

  task automatic accept_rsp_a();
    a_rready = 1'b1;
    @(posedge clk);
    #1 a_rready = 1'b0;
  endtask

  typedef struct {
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [1:0]  size;
    logic [31:0] rdat;
    int unsigned err_beat;
    logic        both;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int unsigned exp_beats;
    logic [31:0] exp_adr0;
    logic [7:0]  exp_d0;
    logic [31:0] exp_adrl;
  } vec_t;

  vec_t vt [9];

  initial begin
    int unsigned lat;
    int unsigned n;
    int unsigned b0;
    logic [31:0] hold_rdata;

    vt[0] = '{1'b1, 32'h100, 32'h0,        4'h0,    2'd2, 32'h44332211, 99, 1'b0, 32'h44332211, 1'b0, 4, 32'h100, 8'h00, 32'h103};
    vt[1] = '{1'b0, 32'h200, 32'hAABBCCDD, 4'b0100, 2'd2, 32'h0,        99, 1'b0, 32'h0,        1'b0, 1, 32'h202, 8'hBB, 32'h202};
    vt[2] = '{1'b1, 32'h101, 32'h0,        4'h0,    2'd0, 32'h0000005A, 99, 1'b0, 32'h00005A00, 1'b0, 1, 32'h101, 8'h00, 32'h101};
    vt[3] = '{1'b1, 32'h102, 32'h0,        4'h0,    2'd1, 32'h00003412, 99, 1'b0, 32'h34120000, 1'b0, 2, 32'h102, 8'h00, 32'h103};
    vt[4] = '{1'b0, 32'h204, 32'h12345678, 4'b0000, 2'd2, 32'h0,        99, 1'b0, 32'h0,        1'b0, 0, 32'h0,   8'h00, 32'h0};
    vt[5] = '{1'b0, 32'h040, 32'h11223344, 4'b1010, 2'd2, 32'h0,        99, 1'b0, 32'h0,        1'b0, 2, 32'h041, 8'h33, 32'h043};
    vt[6] = '{1'b0, 32'h300, 32'h01020304, 4'b1111, 2'd2, 32'h0,        1,  1'b0, 32'h0,        1'b1, 2, 32'h300, 8'h04, 32'h301};
    vt[7] = '{1'b1, 32'h104, 32'h0,        4'h0,    2'd2, 32'h99887766, 0,  1'b1, 32'h0,        1'b1, 1, 32'h104, 8'h00, 32'h104};
    vt[8] = '{1'b1, 32'h10B, 32'h0,        4'h0,    2'd0, 32'h000000C3, 99, 1'b0, 32'hC3000000, 1'b0, 1, 32'h10B, 8'h00, 32'h10B};

    // Reset state
    @(negedge clk);
    chk("rst_cmd_ready", {31'd0, a_cready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, a_rvalid}, 32'd0);
    chk("rst_cyc",       {31'd0, a_cyc},    32'd0);
    chk("rst_rdata",     a_rdata,           32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", {31'd0, a_cready}, 32'd1);

    // Table-driven transactions on the 8-bit bridge
    for (int i = 0; i < 9; i++) begin
      a_rdat = vt[i].rdat; a_err_beat = vt[i].err_beat; a_both = vt[i].both;
      base = beat_cnt;
      issue_a(vt[i].rd, vt[i].addr, vt[i].wdata, vt[i].wmask, vt[i].size);
      wait_rsp_a(lat);
      b0 = base;
      chk($sformatf("v%0d_rsp_valid", i), {31'd0, a_rvalid}, 32'd1);
      chk($sformatf("v%0d_latency", i), lat, 1 + vt[i].exp_beats);
      chk($sformatf("v%0d_err", i), {31'd0, a_rerr}, {31'd0, vt[i].exp_err});
      chk($sformatf("v%0d_beats", i), beat_cnt - b0, vt[i].exp_beats);
      if (vt[i].rd) chk($sformatf("v%0d_rdata", i), a_rdata, vt[i].exp_rdata);
      if (vt[i].exp_beats > 0) begin
        chk($sformatf("v%0d_adr0", i), log_adr[b0[7:0]], vt[i].exp_adr0);
        chk($sformatf("v%0d_sel0", i), {31'd0, log_sel[b0[7:0]]}, 32'd1);
        chk($sformatf("v%0d_we0", i), {31'd0, log_we[b0[7:0]]}, {31'd0, !vt[i].rd});
        if (!vt[i].rd) chk($sformatf("v%0d_dat0", i), {24'd0, log_dat[b0[7:0]]}, {24'd0, vt[i].exp_d0});
        chk($sformatf("v%0d_adrl", i), log_adr[8'(b0 + vt[i].exp_beats - 1)], vt[i].exp_adrl);
      end
      accept_rsp_a();
      a_err_beat = 99; a_both = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_idle_ready", i), {31'd0, a_cready}, 32'd1);
    end

    // Timeout: no ack, stb high for exactly 4 cycles, then a held response
    a_ack_en = 1'b0;
    issue_a(1'b0, 32'h10, 32'h0000_00A5, 4'b0001, 2'd0);
    n = 0; lat = 0;
    do begin @(negedge clk); lat++; if (a_stb) n++; end while (a_stb && lat < 20);
    chk("tmo_stb_cycles", n, 32'd4);
    chk("tmo_rsp_valid", {31'd0, a_rvalid}, 32'd1);
    chk("tmo_err", {31'd0, a_rerr}, 32'd1);
    hold_rdata = a_rdata;
    a_cvalid = 1'b1; a_cread = 1'b1; a_csize = 2'd2;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_rsp_valid", k), {31'd0, a_rvalid}, 32'd1);
      chk($sformatf("hold%0d_err", k), {31'd0, a_rerr}, 32'd1);
      chk($sformatf("hold%0d_rdata", k), a_rdata, hold_rdata);
      chk($sformatf("hold%0d_cmd_ready", k), {31'd0, a_cready}, 32'd0);
      chk($sformatf("hold%0d_cyc", k), {31'd0, a_cyc}, 32'd0);
    end
    a_cvalid = 1'b0;
    accept_rsp_a();
    @(negedge clk);
    chk("tmo_after_ready", {31'd0, a_cready}, 32'd1);
    chk("tmo_after_valid", {31'd0, a_rvalid}, 32'd0);

    // Asynchronous reset in the middle of a beat
    issue_a(1'b0, 32'h20, 32'hFFFF_FFFF, 4'b1111, 2'd2);
    @(negedge clk);
    chk("mid_beat_cyc", {31'd0, a_cyc}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_cyc", {31'd0, a_cyc}, 32'd0);
    chk("async_rst_stb", {31'd0, a_stb}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    a_ack_en = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", {31'd0, a_cready}, 32'd1);
    chk("rst_release_rsp",   {31'd0, a_rvalid}, 32'd0);

    // 16-bit bridge: half read at 0x302
    @(negedge clk);
    b_cvalid = 1'b1; b_cread = 1'b1; b_caddr = 32'h302; b_csize = 2'd1;
    n = 0;
    while (!b_cready && n < 20) begin @(negedge clk); n++; end
    chk("b_rd_accept", {31'd0, b_cready}, 32'd1);
    @(posedge clk);
    #1 b_cvalid = 1'b0;
    @(negedge clk);
    chk("b_rd_stb", {31'd0, b_stb}, 32'd1);
    chk("b_rd_adr", b_adr, 32'h302);
    chk("b_rd_sel", {30'd0, b_sel}, 32'h3);
    @(negedge clk);
    chk("b_rd_rsp_valid", {31'd0, b_rvalid}, 32'd1);
    chk("b_rd_rdata", b_rdata, 32'hBEEF0000);
    chk("b_rd_err", {31'd0, b_rerr}, 32'd0);
    b_rready = 1'b1;
    @(posedge clk);
    #1 b_rready = 1'b0;

    // 16-bit bridge: write spanning both groups
    @(negedge clk);
    b_cvalid = 1'b1; b_cread = 1'b0; b_caddr = 32'h8; b_cwdata = 32'h11223344; b_cwmask = 4'b0110;
    n = 0;
    while (!b_cready && n < 20) begin @(negedge clk); n++; end
    chk("b_wr_accept", {31'd0, b_cready}, 32'd1);
    @(posedge clk);
    #1 b_cvalid = 1'b0;
    @(negedge clk);
    chk("b_wr0_adr", b_adr, 32'h8);
    chk("b_wr0_sel", {30'd0, b_sel}, 32'h2);
    chk("b_wr0_dat", {16'd0, b_dat_w}, 32'h3344);
    chk("b_wr0_we",  {31'd0, b_we}, 32'd1);
    @(negedge clk);
    chk("b_wr1_stb", {31'd0, b_stb}, 32'd1);
    chk("b_wr1_adr", b_adr, 32'hA);
    chk("b_wr1_sel", {30'd0, b_sel}, 32'h1);
    chk("b_wr1_dat", {16'd0, b_dat_w}, 32'h1122);
    @(negedge clk);
    chk("b_wr_rsp_valid", {31'd0, b_rvalid}, 32'd1);
    chk("b_wr_stb_low", {31'd0, b_stb}, 32'd0);
    b_rready = 1'b1;
    @(posedge clk);
    #1 b_rready = 1'b0;

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
